// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised packet FIFO.
// FIFO_ENTRY_T builds the {src,dst,data} packed entry at the widths chosen by the instantiating module.

`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_ENTRY_T(name, sw, dw, daw) \
  typedef struct packed { \
    logic [(sw)-1:0]  src; \
    logic [(dw)-1:0]  dst; \
    logic [(daw)-1:0] data; \
  } name

package fifo_pkg;

  // Reset level of the asynchronous reset input.
  localparam logic RST_ACTIVE = 1'b0;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/fifo_ram.sv
// Storage array for the packet FIFO: one write port and one registered read port.
// The read register holds its value unless a read is enabled.

module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Store the write entry; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Register the addressed entry on a read; a same-edge write at the same slot is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) rdata_q <= '0;
    else if (re_i)         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised {src,dst,data} packet FIFO with occupancy count and almost-full/empty flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.

module fifo_param
  import fifo_pkg::*;
#(
  parameter int SRC_W  = 8,
  parameter int DST_W  = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SRC_W-1:0]          src_in,
  input  logic [DST_W-1:0]          dst_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      writep,
  input  logic                      readp,
  output logic [SRC_W-1:0]          src_out,
  output logic [DST_W-1:0]          dst_out,
  output logic [DATA_W-1:0]         data_out,
  output logic                      emptyp,
  output logic                      fullp,
  output logic                      almost_emptyp,
  output logic                      almost_fullp,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                      ovf_err,
  output logic                      udf_err,
`endif
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int ENT_W = SRC_W + DST_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LVL);

  `FIFO_ENTRY_T(fifo_entry_t, SRC_W, DST_W, DATA_W);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             emptyp_q, fullp_q, aempty_q, afull_q;
  logic             emptyp_d, fullp_d, aempty_d, afull_d;
  logic             rd_ok, wr_ok;

  fifo_entry_t      wr_entry;
  fifo_entry_t      rd_entry;
  logic [ENT_W-1:0] rd_bits;

  // A read frees a slot on the same edge, so a write at full is still accepted alongside it.
  always_comb begin
    rd_ok    = readp & ~emptyp_q;
    wr_ok    = writep & (~fullp_q | rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    emptyp_d = (count_d == '0);
    fullp_d  = (count_d == FULL_C);
    aempty_d = (count_d <= AE_C);
    afull_d  = (count_d >= AF_C);
  end

  // Pointers, occupancy and flags; flags come from next-count so they line up with count.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      emptyp_q <= 1'b1;
      fullp_q  <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= (AF_LVL == 0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      emptyp_q <= emptyp_d;
      fullp_q  <= fullp_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (writep & ~wr_ok)  ovf_q <= 1'b1;
      if (readp & emptyp_q) udf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

  assign wr_entry.src  = src_in;
  assign wr_entry.dst  = dst_in;
  assign wr_entry.data = data_in;

  fifo_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_bits)
  );

  assign rd_entry      = fifo_entry_t'(rd_bits);
  assign src_out       = rd_entry.src;
  assign dst_out       = rd_entry.dst;
  assign data_out      = rd_entry.data;
  assign count         = count_q;
  assign emptyp        = emptyp_q;
  assign fullp         = fullp_q;
  assign almost_emptyp = aempty_q;
  assign almost_fullp  = afull_q;

endmodule
